// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the front-panel button debouncer.
//   btn_state_t  : per-channel debounce FSM state (2 bits)
//   BTN_IDLE_LVL : pad level of a released (active-low) button
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam logic BTN_IDLE_LVL = 1'b1;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel.
// Contains the synchroniser chain, the counter-based debounce FSM and the
// registered press/release strobes. When BTN_REPEAT_EN is defined, it also
// contains hold-to-auto-repeat.
// Ports:
//   CLK      : system clock
//   RESETn   : asynchronous active-low reset
//   iPad     : raw pad input, active-low, asynchronous to CLK
//   oLevel   : debounced level, 1 = pressed
//   oPress   : one-cycle strobe on committed press (plus repeat strobes)
//   oRelease : one-cycle strobe on committed release
// Macro: BTN_REPEAT_EN enables the auto-repeat counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] DEBOUNCE_CYC  = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1000000
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic iPad,
  output logic oLevel,
  output logic oPress,
  output logic oRelease
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYC) + 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   s;
  btn_state_t             stateQ, stateD;
  logic [CNT_W-1:0]       cntQ, cntD;
  logic                   levelQ, levelD;
  logic                   pressQ, pressD;
  logic                   releaseQ, releaseD;
  logic                   rptHit;

  // Plain shift chain; only the last stage feeds the FSM.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) syncQ <= {SYNC_STAGES{BTN_IDLE_LVL}};
    else         syncQ <= {syncQ[SYNC_STAGES-2:0], iPad};
  end

  assign s = syncQ[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateQ   <= RELEASED;
      cntQ     <= '0;
      levelQ   <= 1'b0;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      levelQ   <= levelD;
      pressQ   <= pressD;
      releaseQ <= releaseD;
    end
  end

  // The entry cycle counts as the first stable sample, so a commit happens
  // on the DEBOUNCE_CYC-th consecutive stable sample.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    levelD   = levelQ;
    pressD   = rptHit;
    releaseD = 1'b0;
    unique case (stateQ)
      RELEASED: begin
        if (s != BTN_IDLE_LVL) begin
          stateD = PRESS_CHK;
          cntD   = CNT_W'(1);
        end
      end
      PRESS_CHK: begin
        if (s == BTN_IDLE_LVL) begin
          stateD = RELEASED;
          cntD   = '0;
        end else if (cntQ == CNT_W'(DEBOUNCE_CYC - 16'd1)) begin
          stateD = PRESSED;
          cntD   = '0;
          levelD = 1'b1;
          pressD = 1'b1;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s == BTN_IDLE_LVL) begin
          stateD = RELEASE_CHK;
          cntD   = CNT_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (s != BTN_IDLE_LVL) begin
          stateD = PRESSED;
          cntD   = '0;
        end else if (cntQ == CNT_W'(DEBOUNCE_CYC - 16'd1)) begin
          stateD   = RELEASED;
          cntD     = '0;
          levelD   = 1'b0;
          releaseD = 1'b1;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      default: begin
        stateD = RELEASED;
        cntD   = '0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (int'(REPEAT_DELAY) > int'(REPEAT_PERIOD)) ?
                           int'(REPEAT_DELAY) : int'(REPEAT_PERIOD);
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rptCntQ;
  logic             rptFirstQ;   // first (long) delay already elapsed
  logic             rptClr;

  // Cleared on a fresh press commit and on a release commit; a bounce back
  // from RELEASE_CHK keeps the count.
  assign rptClr = (stateQ == PRESS_CHK && stateD == PRESSED) || releaseD;

  assign rptHit = (stateQ == PRESSED) &&
                  (rptFirstQ ? (rptCntQ == RPT_W'(REPEAT_PERIOD - 24'd1))
                             : (rptCntQ == RPT_W'(REPEAT_DELAY  - 24'd1)));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rptCntQ   <= '0;
      rptFirstQ <= 1'b0;
    end else if (rptClr) begin
      rptCntQ   <= '0;
      rptFirstQ <= 1'b0;
    end else if (stateQ == PRESSED) begin
      if (rptHit) begin
        rptCntQ   <= '0;
        rptFirstQ <= 1'b1;
      end else begin
        rptCntQ <= rptCntQ + RPT_W'(1);
      end
    end
  end
`else
  assign rptHit = 1'b0;
`endif

  assign oLevel   = levelQ;
  assign oPress   = pressQ;
  assign oRelease = releaseQ;

endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N_BTN independent debounced button channels.
// Ports:
//   CLK         : system clock
//   RESETn      : asynchronous active-low reset
//   iExtBtn     : raw pad inputs, active-low (1 = released)
//   oBtnLevel   : debounced levels, 1 = pressed
//   oBtnPress   : one-cycle press strobes (plus repeat strobes)
//   oBtnRelease : one-cycle release strobes
// Macro: BTN_REPEAT_EN enables hold-to-auto-repeat on every channel.
module btn_debounce_multi #(
  parameter int          N_BTN         = 4,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] DEBOUNCE_CYC  = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1000000
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [N_BTN-1:0] iExtBtn,
  output logic [N_BTN-1:0] oBtnLevel,
  output logic [N_BTN-1:0] oBtnPress,
  output logic [N_BTN-1:0] oBtnRelease
);

  for (genvar i = 0; i < N_BTN; i++) begin : gCh
    btn_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) uCh (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .iPad    (iExtBtn[i]),
      .oLevel  (oBtnLevel[i]),
      .oPress  (oBtnPress[i]),
      .oRelease(oBtnRelease[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
module tb_btn_debounce_multi;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [3:0] iExtBtn;
  logic [3:0] oBtnLevel, oBtnPress, oBtnRelease;

  int checks   = 0;
  int failures = 0;

  btn_debounce_multi #(
    .N_BTN        (4),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (16'd8),
    .REPEAT_DELAY (24'd20),
    .REPEAT_PERIOD(24'd5)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .iExtBtn    (iExtBtn),
    .oBtnLevel  (oBtnLevel),
    .oBtnPress  (oBtnPress),
    .oBtnRelease(oBtnRelease)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk3(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                      input logic [3:0] rel);
    chk({tag, ".level"},   oBtnLevel,   lvl);
    chk({tag, ".press"},   oBtnPress,   prs);
    chk({tag, ".release"}, oBtnRelease, rel);
  endtask

  initial begin
    logic expRpt;
    RESETn  = 1'b0;
    iExtBtn = 4'hF;
    tick(3);
    chk3("reset", 4'h0, 4'h0, 4'h0);
    RESETn = 1'b1;
    tick(2);
    chk3("idle", 4'h0, 4'h0, 4'h0);

    // Clean press / release on channel 0: commit on edge 10.
    iExtBtn[0] = 1'b0;
    tick(9);
    chk3("press_e9", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk3("press_e10", 4'h1, 4'h1, 4'h0);
    tick(1);
    chk3("press_e11", 4'h1, 4'h0, 4'h0);
    iExtBtn[0] = 1'b1;
    tick(9);
    chk3("rel_e9", 4'h1, 4'h0, 4'h0);
    tick(1);
    chk3("rel_e10", 4'h0, 4'h0, 4'h1);
    tick(1);
    chk3("rel_e11", 4'h0, 4'h0, 4'h0);

    // Bounce on channel 1: low 7, high 1, low 7, high.
    iExtBtn[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(1); chk3("bounce_a", 4'h0, 4'h0, 4'h0); end
    iExtBtn[1] = 1'b1;
    tick(1);
    chk3("bounce_b", 4'h0, 4'h0, 4'h0);
    iExtBtn[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(1); chk3("bounce_c", 4'h0, 4'h0, 4'h0); end
    iExtBtn[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(1); chk3("bounce_d", 4'h0, 4'h0, 4'h0); end

    // Simultaneous press / release on channels 2 and 3.
    iExtBtn[3:2] = 2'b00;
    tick(9);
    chk3("sim_e9", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk3("sim_e10", 4'hC, 4'hC, 4'h0);
    tick(1);
    chk3("sim_e11", 4'hC, 4'h0, 4'h0);
    iExtBtn[3:2] = 2'b11;
    tick(10);
    chk3("simrel_e10", 4'h0, 4'h0, 4'hC);
    tick(1);
    chk3("simrel_e11", 4'h0, 4'h0, 4'h0);

    // Reset during PRESS_CHK.
    iExtBtn[0] = 1'b0;
    tick(5);
    RESETn = 1'b0;
    #1;
    chk3("rst_chk_async", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk3("rst_chk_held", 4'h0, 4'h0, 4'h0);

    // Button still held: fresh press 10 edges after reset release.
    RESETn = 1'b1;
    tick(9);
    chk3("rehold_e9", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk3("rehold_e10", 4'h1, 4'h1, 4'h0);
    tick(1);

    // Reset while PRESSED: level drops, no release strobe.
    RESETn = 1'b0;
    #1;
    chk3("rst_prs_async", 4'h0, 4'h0, 4'h0);
    tick(2);
    chk3("rst_prs_held", 4'h0, 4'h0, 4'h0);
    iExtBtn[0] = 1'b1;
    RESETn     = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(1); chk3("rst_after", 4'h0, 4'h0, 4'h0); end

    // Hold channel 0 for 50 cycles past the commit.
    iExtBtn[0] = 1'b0;
    tick(10);
    chk3("hold_commit", 4'h1, 4'h1, 4'h0);
    for (int k = 1; k <= 50; k++) begin
      tick(1);
`ifdef BTN_REPEAT_EN
      expRpt = (k >= 20) && (((k - 20) % 5) == 0);
`else
      expRpt = 1'b0;
`endif
      chk3("hold_rpt", 4'h1, {3'b000, expRpt}, 4'h0);
    end

    // 3-cycle release glitch while PRESSED.
    iExtBtn[0] = 1'b1;
    tick(3);
    iExtBtn[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("glitch.level",   oBtnLevel,   4'h1);
      chk("glitch.release", oBtnRelease, 4'h0);
    end

    // Clean final release; press must stay low on the commit edge.
    iExtBtn[0] = 1'b1;
    tick(10);
    chk("final.level",   oBtnLevel,   4'h0);
    chk("final.release", oBtnRelease, 4'h1);
    chk("final.press",   oBtnPress,   4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
